// File: rtl/contador_modular_param.sv
// Parametrised modulo counter: up/down, enable, sync clear/load, wrap or saturate,
// with registered terminal-count pulse and sticky over/underflow flag.
module contador_modular_param #(
  parameter int              WIDTH    = 3,
  parameter longint unsigned MODULO   = 8,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  // Top of range held in WIDTH+1 bits so MODULO = 2^WIDTH compares without carry loss.
  localparam longint unsigned MAX_L = MODULO - 64'd1;
  localparam logic [WIDTH:0]   MAX_X = MAX_L[WIDTH:0];
  localparam logic [WIDTH-1:0] MAX_W = MAX_L[WIDTH-1:0];

  if (WIDTH < 2 || WIDTH > 32 || MODULO < 2 || MODULO > (64'd1 << WIDTH)) begin : g_param_chk
    $error("contador_modular_param: illegal WIDTH/MODULO combination");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   count_x;
  logic [WIDTH:0]   load_x;
  logic             at_top;
  logic             at_bot;

  always_comb begin
    count_x = {1'b0, count_q};
    load_x  = {1'b0, load_val};
    at_top  = (count_x == MAX_X);
    at_bot  = (count_q == '0);

    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;

    if (clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = (load_x > MAX_X) ? MAX_W : load_val;
    end else if (en) begin
      if (up_down) begin
        if (at_top) begin
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
          count_d = SATURATE ? MAX_W : '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (at_bot) begin
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
          count_d = SATURATE ? '0 : MAX_W;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_contador_modular_param.sv
// Bench for contador_modular_param: three configurations driven in parallel,
// directed vector table, hand sequences and random stimulus against a model.
module tb_contador_modular_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0, up_down = 1'b0, clear = 1'b0, load = 1'b0;
  logic [3:0] lv = 4'd0;

  logic [2:0] c0, c1;
  logic [3:0] c2;
  logic       t0, t1, t2, o0, o1, o2;

  always #5 clk = ~clk;

  contador_modular_param #(.WIDTH(3), .MODULO(6), .SATURATE(1'b0)) u_wrap6 (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .clear(clear), .load(load),
    .load_val(lv[2:0]), .count(c0), .tc(t0), .ovf(o0));
  contador_modular_param #(.WIDTH(3), .MODULO(6), .SATURATE(1'b1)) u_sat6 (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .clear(clear), .load(load),
    .load_val(lv[2:0]), .count(c1), .tc(t1), .ovf(o1));
  contador_modular_param #(.WIDTH(4), .MODULO(16), .SATURATE(1'b0)) u_wrap16 (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .clear(clear), .load(load),
    .load_val(lv), .count(c2), .tc(t2), .ovf(o2));

  int n_chk = 0, n_pass = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // Reference model: count as an integer, boundary = step leaving [0, MOD-1].
  int mod_v[3] = '{6, 6, 16};
  bit sat_v[3] = '{1'b0, 1'b1, 1'b0};
  int lmask[3] = '{7, 7, 15};
  int mc[3], mt[3], mo[3];

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (reset || clear) begin
        mc[i] = 0; mt[i] = 0; mo[i] = 0;
      end else if (load) begin
        int v;
        v = int'(lv) & lmask[i];
        mc[i] = (v > mod_v[i] - 1) ? mod_v[i] - 1 : v;
        mt[i] = 0;
      end else if (en) begin
        int nxt;
        nxt = mc[i] + (up_down ? 1 : -1);
        if (nxt < 0 || nxt >= mod_v[i]) begin
          mt[i] = 1; mo[i] = 1;
          if (!sat_v[i]) mc[i] = (nxt + mod_v[i]) % mod_v[i];
        end else begin
          mc[i] = nxt; mt[i] = 0;
        end
      end else begin
        mt[i] = 0;
      end
    end
  endtask

  function automatic logic [31:0] act_cnt(int i);
    case (i)
      0: return 32'(c0);
      1: return 32'(c1);
      default: return 32'(c2);
    endcase
  endfunction
  function automatic logic act_tc(int i);
    return (i == 0) ? t0 : (i == 1) ? t1 : t2;
  endfunction
  function automatic logic act_ovf(int i);
    return (i == 0) ? o0 : (i == 1) ? o1 : o2;
  endfunction

  task automatic drive(bit clr, bit ld, bit e, bit u, logic [3:0] v);
    clear = clr; load = ld; en = e; up_down = u; lv = v;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic expect_dut(int i, string nm, int ec, int et, int eo);
    chk({nm, ".count"}, act_cnt(i), ec);
    chk({nm, ".tc"}, 32'(act_tc(i)), et);
    chk({nm, ".ovf"}, 32'(act_ovf(i)), eo);
  endtask

  typedef struct {
    bit clr, ld, e, u;
    logic [3:0] v;
    int ec, et, eo;
  } vec_t;
  vec_t tbl[$];

  initial begin
    for (int i = 0; i < 3; i++) begin mc[i] = 0; mt[i] = 0; mo[i] = 0; end

    // clr ld en up lv  count tc ovf  (MODULO=6 wrap instance)
    for (int k = 0; k < 8; k++) tbl.push_back('{0,0,1,1,4'd0, (k + 1) % 6, (k == 5), (k >= 5)});
    tbl.push_back('{1,0,1,1,4'd0, 0,0,0});
    tbl.push_back('{0,0,1,0,4'd0, 5,1,1});
    tbl.push_back('{0,0,1,0,4'd0, 4,0,1});
    tbl.push_back('{0,0,1,0,4'd0, 3,0,1});
    tbl.push_back('{1,0,0,0,4'd0, 0,0,0});
    tbl.push_back('{0,1,0,0,4'd7, 5,0,0});
    tbl.push_back('{0,1,1,1,4'd3, 3,0,0});
    tbl.push_back('{1,1,1,1,4'd2, 0,0,0});
    tbl.push_back('{0,0,0,1,4'd0, 0,0,0});
    tbl.push_back('{0,0,1,1,4'd0, 1,0,0});
    tbl.push_back('{0,1,0,0,4'd5, 5,0,0});
    tbl.push_back('{0,0,1,1,4'd0, 0,1,1});
    tbl.push_back('{0,1,0,0,4'd2, 2,0,1});
    tbl.push_back('{0,0,0,0,4'd0, 2,0,1});

    // Reset state, held across an enabled edge
    drive(0, 0, 1, 1, 4'd0);
    #1;
    for (int i = 0; i < 3; i++) expect_dut(i, "reset_async", 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) expect_dut(i, "reset_held", 0, 0, 0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 4'd0);

    foreach (tbl[k]) begin
      drive(tbl[k].clr, tbl[k].ld, tbl[k].e, tbl[k].u, tbl[k].v);
      tick();
      expect_dut(0, $sformatf("vec%0d", k), tbl[k].ec, tbl[k].et, tbl[k].eo);
    end

    // Saturate: run to top, push past it three times, then step down
    drive(1, 0, 0, 0, 4'd0); tick();
    drive(0, 0, 1, 1, 4'd0);
    for (int k = 0; k < 5; k++) tick();
    expect_dut(1, "sat_top", 5, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_dut(1, $sformatf("sat_hold%0d", k), 5, 1, 1);
    end
    drive(0, 0, 1, 0, 4'd0); tick();
    expect_dut(1, "sat_down", 4, 0, 1);
    drive(1, 0, 0, 0, 4'd0); tick();
    drive(0, 0, 1, 0, 4'd0); tick();
    expect_dut(1, "sat_bot", 0, 1, 1);

    // Full-range width: 15 -> 0 and load/hold at 15
    drive(0, 1, 0, 0, 4'd15); tick();
    expect_dut(2, "w16_load", 15, 0, 1);
    drive(0, 0, 1, 1, 4'd0); tick();
    expect_dut(2, "w16_wrap", 0, 1, 1);
    drive(0, 1, 0, 0, 4'd15); tick();
    drive(0, 0, 0, 1, 4'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_dut(2, $sformatf("w16_hold%0d", k), 15, 0, 1);
    end

    // Async reset mid-cycle with ovf set and count=4
    drive(1, 0, 0, 0, 4'd0); tick();
    drive(0, 0, 1, 1, 4'd0);
    for (int k = 0; k < 10; k++) tick();
    expect_dut(0, "pre_reset", 4, 0, 1);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) expect_dut(i, "mid_reset", 0, 0, 0);
    tick(); tick();
    for (int i = 0; i < 3; i++) expect_dut(i, "reset_2edges", 0, 0, 0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) expect_dut(i, "post_reset", 1, 0, 0);

    // Randomised traffic against the model
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
      tick();
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("rnd%0d.u%0d.count", k, i), act_cnt(i), mc[i]);
        chk($sformatf("rnd%0d.u%0d.tc", k, i), 32'(act_tc(i)), mt[i]);
        chk($sformatf("rnd%0d.u%0d.ovf", k, i), 32'(act_ovf(i)), mo[i]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
